spi_cntrl: RTL and testbench



---
 rtl/spi_cntrl.sv | 149 ++++++++++++++
 tb/tb_spi_cntrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cntrl.sv
// SPI mode-0 (CPOL=0, CPHA=0) main controller, MSB first, one DATA_WIDTH-bit word per
// start/done handshake; hold_cs chains words under a single chip-select assertion.
`timescale 1ns/1ps
module spi_cntrl #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_to_send,
    input  logic                  hold_cs,
    output logic [DATA_WIDTH-1:0] data_received,
    output logic                  busy,
    output logic                  done,
    output logic                  SPI_SCLK,
    output logic                  SPI_MOSI,
    input  logic                  SPI_MISO,
    output logic                  SPI_CS
);
    localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;
    localparam int BW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] PH_LAST  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    if (HALF < 2 || (CLK_FREQUENCY % (2 * SCLK_FREQUENCY)) != 0 || DATA_WIDTH < 2) begin : g_bad_params
        $fatal(1, "spi_cntrl: SCLK phase must be an integer of at least 2 clocks and DATA_WIDTH >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        WAIT_NEXT
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         phase_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rx_word_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  cs_q;
    logic                  busy_q;
    logic                  done_q;

    wire phase_last = (phase_q == PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_word_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, WAIT_NEXT: begin
                    if (start) begin
                        tx_q    <= data_to_send;
                        mosi_q  <= data_to_send[DATA_WIDTH-1];
                        bit_q   <= '0;
                        phase_q <= '0;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end else if (state_q == WAIT_NEXT && !hold_cs) begin
                        cs_q    <= 1'b1;
                        mosi_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    if (phase_last) begin
                        sclk_q  <= 1'b1;
                        phase_q <= '0;
                        state_q <= HIGH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                HIGH: begin
                    // MISO is sampled just before the falling edge, where the subunit shifts.
                    if (phase_last) begin
                        rx_q    <= {rx_q[DATA_WIDTH-2:0], SPI_MISO};
                        sclk_q  <= 1'b0;
                        phase_q <= '0;
                        state_q <= LOW;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                LOW: begin
                    if (phase_q == '0) begin
                        tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b1};
                        mosi_q <= tx_q[DATA_WIDTH-2];
                    end
                    if (phase_last) begin
                        phase_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            rx_word_q <= rx_q;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            if (hold_cs) begin
                                state_q <= WAIT_NEXT;
                            end else begin
                                cs_q    <= 1'b1;
                                mosi_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            sclk_q  <= 1'b1;
                            state_q <= HIGH;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_received = rx_word_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign SPI_SCLK      = sclk_q;
    assign SPI_MOSI      = mosi_q;
    assign SPI_CS        = cs_q;

endmodule

// File: tb/tb_spi_cntrl.sv
// Scoreboard bench for spi_cntrl with a behavioural mode-0 subunit (HALF = 5 clocks).
`timescale 1ns/1ps
module tb_spi_cntrl;
    localparam int DW       = 8;
    localparam int HALF     = 5;
    localparam int WORD_CYC = (2 * DW + 1) * HALF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] data_to_send;
    logic          hold_cs;
    logic [DW-1:0] data_received;
    logic          busy, done;
    logic          SPI_SCLK, SPI_MOSI, SPI_MISO, SPI_CS;

    always #5 clk = ~clk;

    spi_cntrl #(
        .CLK_FREQUENCY (100_000_000),
        .SCLK_FREQUENCY(10_000_000),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_to_send (data_to_send),
        .hold_cs      (hold_cs),
        .data_received(data_received),
        .busy         (busy),
        .done         (done),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_MISO     (SPI_MISO),
        .SPI_CS       (SPI_CS)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_rx_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] exp_sub_q[$];
    logic [DW-1:0] sub_tx_q[$];

    int   cs_falls = 0, cs_rises = 0, done_count = 0, sclk_rises = 0;
    logic sub_miso = 1'b0;
    assign SPI_MISO = sub_miso;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Subunit model and output monitor, both observed on the falling clk edge.
    initial begin : monitor
        logic          cs_prev, sclk_prev, mosi_prev, done_prev, mosi_at_rise;
        logic [DW-1:0] sub_sh, sub_rx, e;
        int            sub_bits, mosi_age, cs_fall_cyc, cs_words, ec;
        longint        last_rise_t;
        cs_prev = 1'b1; sclk_prev = 1'b0; mosi_prev = 1'b1; done_prev = 1'b0; mosi_at_rise = 1'b0;
        sub_sh = '0; sub_rx = '0; e = '0; sub_bits = 0; mosi_age = 0;
        cs_fall_cyc = 0; cs_words = 0; ec = 0; last_rise_t = 0;
        forever begin
            @(negedge clk);
            if (SPI_MOSI !== mosi_prev) mosi_age = 0;
            else mosi_age++;
            if (SPI_CS !== cs_prev) check("sclk_low_at_cs_edge", 32'(SPI_SCLK), 32'd0);
            if (cs_prev === 1'b1 && SPI_CS === 1'b0) begin
                cs_falls++;
                cs_fall_cyc = cyc;
                cs_words    = 0;
                sclk_rises  = 0;
                sub_bits    = 0;
                if (sub_tx_q.size() > 0) sub_sh = sub_tx_q.pop_front();
                sub_miso = sub_sh[DW-1];
            end
            if (cs_prev === 1'b0 && SPI_CS === 1'b1) begin
                cs_rises++;
                sub_bits = 0;
            end
            if (SPI_CS === 1'b0 && sclk_prev === 1'b0 && SPI_SCLK === 1'b1) begin
                check("mosi_setup_ge4", 32'(mosi_age >= 4), 32'd1);
                if (sclk_rises > 0) check("sclk_period_ns", 32'($time - last_rise_t), 32'd100);
                last_rise_t  = $time;
                sclk_rises++;
                mosi_at_rise = SPI_MOSI;
                sub_rx       = {sub_rx[DW-2:0], SPI_MOSI};
                sub_bits++;
                if (sub_bits == DW) begin
                    if (exp_sub_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL sub_word: got %02h, expected no word", sub_rx);
                    end else begin
                        e = exp_sub_q.pop_front();
                        check("sub_word", 32'(sub_rx), 32'(e));
                        $display("subunit received %02h (expected %02h)", sub_rx, e);
                    end
                end
            end
            if (SPI_CS === 1'b0 && sclk_prev === 1'b1 && SPI_SCLK === 1'b0) begin
                check("mosi_hold", 32'(SPI_MOSI), 32'(mosi_at_rise));
                if (sub_bits == DW) begin
                    sub_bits = 0;
                    if (sub_tx_q.size() > 0) sub_sh = sub_tx_q.pop_front();
                end else begin
                    sub_sh = {sub_sh[DW-2:0], 1'b0};
                end
                sub_miso = sub_sh[DW-1];
            end
            if (done === 1'b1) begin
                done_count++;
                check("done_width", 32'(done_prev), 32'd0);
                check("busy_at_done", 32'(busy), 32'd0);
                check("sclk_pulses", 32'(sclk_rises), 32'd8);
                if (exp_rx_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL done: got unexpected done with data %02h, expected none", data_received);
                end else begin
                    e  = exp_rx_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("data_received", 32'(data_received), 32'(e));
                    check("done_cycle", 32'(cyc), 32'(ec));
                    $display("done: data_received=%02h expected=%02h cycle=%0d", data_received, e, cyc);
                end
                cs_words++;
                if (SPI_CS === 1'b1)
                    check("cs_low_cycles", 32'(cyc - cs_fall_cyc), 32'(cs_words * WORD_CYC + cs_words - 1));
                sclk_rises = 0;
            end
            cs_prev   = SPI_CS;
            sclk_prev = SPI_SCLK;
            mosi_prev = SPI_MOSI;
            done_prev = done;
        end
    end

    // Call on a falling edge with the controller idle or waiting.
    task automatic issue(input logic [DW-1:0] d, input logic h, input logic [DW-1:0] rx_exp, input bit track);
        data_to_send = d;
        hold_cs      = h;
        start        = 1'b1;
        if (track) begin
            exp_rx_q.push_back(rx_exp);
            exp_sub_q.push_back(d);
        end
        @(posedge clk);
        #1;
        if (track) exp_cyc_q.push_back(cyc + WORD_CYC);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (k == 300) begin
            n_chk++; n_err++;
            $display("FAIL %s: got no done, expected done within 300 cycles", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, 32'(SPI_CS), 32'd1);
        check({tag, "_sclk"}, 32'(SPI_SCLK), 32'd0);
        check({tag, "_mosi"}, 32'(SPI_MOSI), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rx"}, 32'(data_received), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int f0, r0, d0, k;
        rst_n = 1'b0; start = 1'b0; hold_cs = 1'b0; data_to_send = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single word
        sub_tx_q.push_back(8'h3C);
        issue(8'hA5, 1'b0, 8'h3C, 1);
        wait_done("single");
        repeat (3) @(negedge clk);
        check("single_cs_idle", 32'(SPI_CS), 32'd1);

        // MOSI/MISO timing patterns
        sub_tx_q.push_back(8'h01);
        issue(8'h80, 1'b0, 8'h01, 1);
        wait_done("pat80");
        sub_tx_q.push_back(8'h80);
        issue(8'h01, 1'b0, 8'h80, 1);
        wait_done("pat01");
        repeat (4) @(negedge clk);

        // hold_cs burst, each start raised in the done cycle
        f0 = cs_falls; r0 = cs_rises; d0 = done_count;
        sub_tx_q.push_back(8'hC1); sub_tx_q.push_back(8'hD2); sub_tx_q.push_back(8'hE3);
        issue(8'h11, 1'b1, 8'hC1, 1);
        wait_done("burst1");
        issue(8'h22, 1'b1, 8'hD2, 1);
        wait_done("burst2");
        issue(8'h33, 1'b0, 8'hE3, 1);
        wait_done("burst3");
        repeat (4) @(negedge clk);
        check("burst_cs_falls", 32'(cs_falls - f0), 32'd1);
        check("burst_cs_rises", 32'(cs_rises - r0), 32'd1);
        check("burst_dones", 32'(done_count - d0), 32'd3);

        // start while busy is ignored
        d0 = done_count;
        sub_tx_q.push_back(8'h96);
        issue(8'h5A, 1'b0, 8'h96, 1);
        repeat (19) @(negedge clk);
        data_to_send = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        repeat (100) @(negedge clk);
        check("ignore_dones", 32'(done_count - d0), 32'd1);

        // Reset after three SCLK pulses
        d0 = done_count;
        sub_tx_q.push_back(8'h77);
        issue(8'hE7, 1'b0, 8'h00, 0);
        for (k = 0; k < 200 && sclk_rises < 3; k++) @(negedge clk);
        check("reset_mid_reached", 32'(sclk_rises >= 3), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_done", 32'(done_count - d0), 32'd0);
        sub_tx_q.push_back(8'h5A);
        issue(8'hC3, 1'b0, 8'h5A, 1);
        wait_done("after_reset");

        // Extremes
        sub_tx_q.push_back(8'hFF);
        issue(8'h00, 1'b0, 8'hFF, 1);
        wait_done("ext00");
        sub_tx_q.push_back(8'h00);
        issue(8'hFF, 1'b0, 8'h00, 1);
        wait_done("extFF");

        repeat (20) @(negedge clk);
        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        check("sub_queue_drained", 32'(exp_sub_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
